prot_check_sched: RTL and testbench
===================================

// Module: prot_check_sched
// PURPOSE
//  Shares one segment-limit (protection) check datapath between two memory-operand requesters (op0, op1).
//  Per request: end address = base + disp + access bytes; compare against a configurable per-segment limit.
//  Pipelined, one result/cycle, valid/ready both sides; sits in RrAg between reg-read and AG output.
// PARAMETERS
//  NREQ     2    requesters (fixed at 2; round-robin logic assumes 2)
//  NSEG     8    segment limit table entries
//  SEGW     3    segment select width (log2 NSEG)
//  TAGW     4    opaque request tag width
// PORTS
//  clk            in   1          clock, posedge
//  rst            in   1          reset, asynchronous, active-high
//  cfg_we         in   1          write segment limit table
//  cfg_seg        in   SEGW       table index to write
//  cfg_limit      in   32         limit value (last legal byte offset)
//  req_valid      in   NREQ       request valid per requester
//  req_ready      out  NREQ       request accepted this cycle (valid&ready = handshake)
//  req_base       in   NREQ*32    base (reg-file sum); slice i = requester i
//  req_disp       in   NREQ*32    displacement/immediate
//  req_size       in   NREQ*4     one-hot access size: 0001=1B 0010=2B 0100=4B 1000=8B
//  req_seg        in   NREQ*SEGW  segment select
//  req_tag        in   NREQ*TAGW  passed through unchanged
//  out_valid      out  1          result valid
//  out_ready      in   1          consumer accepts result
//  out_src        out  1          requester index of result
//  out_tag        out  TAGW       tag of result
//  out_last_addr  out  32         base+disp+bytes-1, low 32 bits
//  out_fault      out  1          protection exception
//  out_fault_ovf  out  1          fault cause: sum carried past bit 31
//  out_fault_size out  1          fault cause: req_size not one-hot
// BEHAVIOUR
//  Reset (async, immediate): S1/S2 valid=0, rr_ptr=0, all table entries=32'hFFFF_FFFF, all outputs 0.
//  Pipeline: S1 register (operands + captured limit), S2 output register. Accept at edge N -> out_valid at
//   edge N+1 (1-cycle latency). Throughput 1/cycle while out_ready=1.
//  Advance: s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; req_ready[i] = grant[i] & s1_adv.
//  Stall: out_valid & !out_ready -> S2 and all outputs held stable; full S1 held; req_ready=0.
//  Arbitration (combinational from req_valid, rr_ptr): one valid -> grant it; both valid -> grant rr_ptr.
//   On handshake to i, rr_ptr <= ~i. No handshake -> rr_ptr unchanged. Grant need not be held across stalls.
//  Datapath (S1 -> S2): bytes = 1/2/4/8 from one-hot; sum = {2'b0,base}+{2'b0,disp}+bytes-1 (34-bit).
//   out_last_addr = sum[31:0]; ovf = |sum[33:32]; size_bad = !onehot(req_size) (bytes treated as 1).
//   out_fault = ovf | size_bad | (sum[31:0] > limit). last_addr == limit is legal.
//  Limit table: cfg_we writes at edge. Limit captured into S1 at accept edge; write to same index on the
//   same edge -> S1 captures OLD value; new value visible to requests accepted next cycle onward.
//  Reset mid-operation: in-flight S1/S2 contents discarded, no result emitted; table reverts to all-ones.
//  req_* inputs sampled only on handshake; contents of non-granted requester are don't-care.
// STRUCTURE
//  Shared package prot_pkg: size one-hot codes, NSEG/SEGW/TAGW, LIMIT_RST=32'hFFFF_FFFF, s1 struct/field widths.
//  One sub-module: prot_end_addr (combinational size decode, 34-bit sum, compare, fault flags), between S1/S2.
//  Arbiter, limit table, pipeline regs in top; arbiter stays inline (2-way).
// TESTING
//  1) seg0 limit=0x0000_0FFF; op0 base=0x0F00 disp=0xF8 size=1000 -> last=0x0FFF, fault=0; disp=0xF9 -> last=0x1000, fault=1.
//  2) op0&op1 valid every cycle, out_ready=1 -> grants alternate 0,1,0,1 from reset (rr_ptr=0); one result/cycle, tags in order.
//  3) out_ready=0 for 3 cycles with continuous valid -> out_* stable, one more accept fills S1, then req_ready=0; release -> no loss/dup.
//  4) base=0xFFFF_FFF0 disp=0x10 size=0001 -> last=0x0000_0000, out_fault=1, out_fault_ovf=1 (limit all-ones).
//  5) size=0110 -> out_fault=1, out_fault_size=1; size=0000 same.
//  6) cfg_we seg2 limit=0x10 on same edge as seg2 request last=0x20 -> fault=0 (old 0xFFFF_FFFF); next request same addr -> fault=1.
//  7) assert rst with S1 and S2 full mid-stall -> out_valid=0 immediately, table all-ones, rr_ptr=0 after release.

Source files
------------

// File: rtl/prot_pkg.sv
// prot_pkg: shared constants and types for the segment-limit protection checker.
//   - requester / segment / tag widths
//   - one-hot access size codes
//   - reset value of the limit table
//   - S1 pipeline register layout
package prot_pkg;

  localparam int NREQ = 2;
  localparam int NSEG = 8;
  localparam int SEGW = 3;
  localparam int TAGW = 4;

  localparam logic [31:0] LIMIT_RST = 32'hFFFF_FFFF;

  localparam logic [3:0] SIZE_1B = 4'b0001;
  localparam logic [3:0] SIZE_2B = 4'b0010;
  localparam logic [3:0] SIZE_4B = 4'b0100;
  localparam logic [3:0] SIZE_8B = 4'b1000;

  typedef struct packed {
    logic            src;
    logic [TAGW-1:0] tag;
    logic [31:0]     base;
    logic [31:0]     disp;
    logic [3:0]      size;
    logic [31:0]     limit;
  } s1_t;

endpackage

// File: rtl/prot_check_sched_end_addr.sv
// prot_end_addr: combinational end-address computation and limit compare.
//   base, disp  in  32   operand terms
//   size        in  4    one-hot access size (non-one-hot is a fault, treated as 1 byte)
//   limit       in  32   last legal byte offset of the segment
//   last_addr   out 32   base+disp+bytes-1, low 32 bits
//   fault       out 1    any protection violation
//   fault_ovf   out 1    sum carried past bit 31
//   fault_size  out 1    size not one-hot
module prot_end_addr
  import prot_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] disp,
  input  logic [3:0]  size,
  input  logic [31:0] limit,
  output logic [31:0] last_addr,
  output logic        fault,
  output logic        fault_ovf,
  output logic        fault_size
);

  logic [33:0] bytes;
  logic [33:0] sum;

  always_comb begin
    bytes      = 34'd1;
    fault_size = 1'b0;
    case (size)
      SIZE_1B: bytes = 34'd1;
      SIZE_2B: bytes = 34'd2;
      SIZE_4B: bytes = 34'd4;
      SIZE_8B: bytes = 34'd8;
      default: fault_size = 1'b1;
    endcase
    // 34 bits so a carry out of bit 31 from either addition is still visible
    sum        = {2'b00, base} + {2'b00, disp} + bytes - 34'd1;
    last_addr  = sum[31:0];
    fault_ovf  = |sum[33:32];
    fault      = fault_ovf | fault_size | (sum[31:0] > limit);
  end

endmodule

// File: rtl/prot_check_sched.sv
// prot_check_sched: one segment-limit check datapath shared by two requesters.
//   clk, rst                   clock / async active-high reset
//   cfg_we, cfg_seg, cfg_limit limit table write port
//   req_valid/req_ready        per-requester handshake
//   req_base/disp/size/seg/tag per-requester operands, slice i = requester i
//   out_valid/out_ready        result handshake
//   out_src, out_tag           requester index and tag of the result
//   out_last_addr              base+disp+bytes-1
//   out_fault[_ovf|_size]      protection fault and its causes
// Two stages: S1 holds the accepted operands plus the limit read at accept time,
// S2 is the output register. Round-robin 2-way arbiter in front of S1.
module prot_check_sched
  import prot_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [SEGW-1:0]      cfg_seg,
  input  logic [31:0]          cfg_limit,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_base,
  input  logic [NREQ*32-1:0]   req_disp,
  input  logic [NREQ*4-1:0]    req_size,
  input  logic [NREQ*SEGW-1:0] req_seg,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_src,
  output logic [TAGW-1:0]      out_tag,
  output logic [31:0]          out_last_addr,
  output logic                 out_fault,
  output logic                 out_fault_ovf,
  output logic                 out_fault_size
);

  logic [31:0]     limit_tbl [NSEG];
  s1_t             s1_q;
  s1_t             s1_d;
  logic            s1_valid;
  logic            rr_ptr;
  logic [NREQ-1:0] grant;
  logic            s1_adv;
  logic            s2_adv;
  logic            hs;
  logic            sel;
  logic [SEGW-1:0] seg_sel;

  logic [31:0]     ea_last;
  logic            ea_fault;
  logic            ea_ovf;
  logic            ea_size_bad;

  // Limit table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) limit_tbl[i] <= LIMIT_RST;
    end else if (cfg_we) begin
      limit_tbl[cfg_seg] <= cfg_limit;
    end
  end

  // Arbiter and stage advance
  always_comb begin
    s2_adv = !out_valid || out_ready;
    s1_adv = !s1_valid || s2_adv;
    grant  = '0;
    if (req_valid[0] && (!req_valid[1] || !rr_ptr)) grant[0] = 1'b1;
    else if (req_valid[1])                          grant[1] = 1'b1;
    // held low during reset so no handshake can appear while state is cleared
    req_ready = rst ? '0 : (grant & {NREQ{s1_adv}});
    hs        = |req_ready;
    sel       = grant[1];
  end

  // Operand mux of the granted requester; table read here sees the pre-write
  // value on a same-edge cfg write, which is what S1 should capture.
  always_comb begin
    seg_sel     = sel ? req_seg[2*SEGW-1:SEGW] : req_seg[SEGW-1:0];
    s1_d.src    = sel;
    s1_d.tag    = sel ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
    s1_d.base   = sel ? req_base[63:32]        : req_base[31:0];
    s1_d.disp   = sel ? req_disp[63:32]        : req_disp[31:0];
    s1_d.size   = sel ? req_size[7:4]          : req_size[3:0];
    s1_d.limit  = limit_tbl[seg_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (hs) begin
      rr_ptr <= ~sel;
    end
  end

  // S1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= hs;
      if (hs) s1_q <= s1_d;
    end
  end

  prot_end_addr u_end_addr (
    .base       (s1_q.base),
    .disp       (s1_q.disp),
    .size       (s1_q.size),
    .limit      (s1_q.limit),
    .last_addr  (ea_last),
    .fault      (ea_fault),
    .fault_ovf  (ea_ovf),
    .fault_size (ea_size_bad)
  );

  // S2 / outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_src        <= 1'b0;
      out_tag        <= '0;
      out_last_addr  <= '0;
      out_fault      <= 1'b0;
      out_fault_ovf  <= 1'b0;
      out_fault_size <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_src        <= s1_q.src;
        out_tag        <= s1_q.tag;
        out_last_addr  <= ea_last;
        out_fault      <= ea_fault;
        out_fault_ovf  <= ea_ovf;
        out_fault_size <= ea_size_bad;
      end
    end
  end

endmodule

// File: tb/tb_prot_check_sched.sv
// tb_prot_check_sched: directed bench for prot_check_sched.
module tb_prot_check_sched;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_seg;
  logic [31:0] cfg_limit;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_base;
  logic [63:0] req_disp;
  logic [7:0]  req_size;
  logic [5:0]  req_seg;
  logic [7:0]  req_tag;
  logic        out_valid;
  logic        out_ready;
  logic        out_src;
  logic [3:0]  out_tag;
  logic [31:0] out_last_addr;
  logic        out_fault;
  logic        out_fault_ovf;
  logic        out_fault_size;

  logic [31:0] b [2];
  logic [31:0] d [2];
  logic [3:0]  s [2];
  logic [2:0]  g [2];
  logic [3:0]  t [2];

  assign req_base = {b[1], b[0]};
  assign req_disp = {d[1], d[0]};
  assign req_size = {s[1], s[0]};
  assign req_seg  = {g[1], g[0]};
  assign req_tag  = {t[1], t[0]};

  int checks = 0;
  int errors = 0;

  prot_check_sched dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_seg        (cfg_seg),
    .cfg_limit      (cfg_limit),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_base       (req_base),
    .req_disp       (req_disp),
    .req_size       (req_size),
    .req_seg        (req_seg),
    .req_tag        (req_tag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_src        (out_src),
    .out_tag        (out_tag),
    .out_last_addr  (out_last_addr),
    .out_fault      (out_fault),
    .out_fault_ovf  (out_fault_ovf),
    .out_fault_size (out_fault_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Single request from requester i into an empty pipe; returns one cycle after
  // the accept edge, when the result sits on the outputs.
  task automatic do_single(input int i, input logic [31:0] bs, input logic [31:0] ds,
                           input logic [3:0] sz, input logic [2:0] sg, input logic [3:0] tg);
    bit done;
    done = 1'b0;
    b[i] = bs; d[i] = ds; s[i] = sz; g[i] = sg; t[i] = tg;
    req_valid = '0;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 10 && !done; n++) begin
      #1;
      done = req_ready[i];
      @(posedge clk); #1;
    end
    req_valid = '0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL handshake_timeout req%0d: ready never seen, expected within 10 cycles", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last_addr !== 32'h0) begin errors++; $display("FAIL rst_last_addr: got %h expected 0", out_last_addr); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", out_fault); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_limit;
    cfg_we = 1'b1; cfg_seg = 3'd0; cfg_limit = 32'h0000_0FFF;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    do_single(0, 32'h0F00, 32'hF8, 4'b1000, 3'd0, 4'd1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL limit_eq_valid: got %b expected 1", out_valid); end
    checks++; if (out_last_addr !== 32'h0FFF) begin errors++; $display("FAIL limit_eq_last: got %h expected 00000fff", out_last_addr); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL limit_eq_fault: got %b expected 0", out_fault); end
    checks++; if (out_tag !== 4'd1 || out_src !== 1'b0) begin errors++; $display("FAIL limit_eq_tag_src: got %h/%b expected 1/0", out_tag, out_src); end
    do_single(0, 32'h0F00, 32'hF9, 4'b1000, 3'd0, 4'd2);
    checks++; if (out_last_addr !== 32'h1000) begin errors++; $display("FAIL limit_gt_last: got %h expected 00001000", out_last_addr); end
    checks++; if (out_fault !== 1'b1) begin errors++; $display("FAIL limit_gt_fault: got %b expected 1", out_fault); end
    checks++; if (out_fault_ovf !== 1'b0 || out_fault_size !== 1'b0) begin errors++; $display("FAIL limit_gt_causes: got ovf=%b size=%b expected 0/0", out_fault_ovf, out_fault_size); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_rdy;
    apply_reset;
    out_ready = 1'b1;
    b[0] = 32'h2000; d[0] = 32'h0; s[0] = 4'b0001; g[0] = 3'd0;
    b[1] = 32'h3000; d[1] = 32'h0; s[1] = 4'b0001; g[1] = 3'd0;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      t[0] = 4'(k); t[1] = 4'(k);
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
      @(posedge clk); #1;
      if (k >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'(k-1) || out_src !== 1'(k-1)
            || out_last_addr !== (((k-1) % 2 == 0) ? 32'h2000 : 32'h3000)) begin
          errors++;
          $display("FAIL rr_out[%0d]: got v=%b tag=%0d src=%b last=%h expected v=1 tag=%0d src=%0d", k, out_valid, out_tag, out_src, out_last_addr, k-1, (k-1) % 2);
        end
      end
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd5 || out_src !== 1'b1) begin errors++; $display("FAIL rr_tail: got v=%b tag=%0d src=%b expected 1/5/1", out_valid, out_tag, out_src); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_stall;
    logic [1:0] rdy_tab [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
    bit         ordy_tab[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit         vld_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int         tag_tab [6] = '{0, 0, 0, 0, 1, 2};
    int nxt;
    apply_reset;
    nxt = 0;
    for (int i = 0; i < 2; i++) begin d[i] = 32'h3; s[i] = 4'b0001; g[i] = 3'd0; end
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) begin t[i] = 4'(nxt); b[i] = 32'h1000 + 32'(nxt) * 32'h10; end
      out_ready = ordy_tab[k];
      #1;
      checks++; if (req_ready !== rdy_tab[k]) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected %b", k, req_ready, rdy_tab[k]); end
      @(posedge clk); #1;
      if (rdy_tab[k] != 2'b00) nxt++;
      checks++;
      if (out_valid !== vld_tab[k] ||
          (vld_tab[k] && (out_tag !== 4'(tag_tab[k]) || out_src !== 1'(tag_tab[k])
                          || out_last_addr !== 32'h1003 + 32'(tag_tab[k]) * 32'h10))) begin
        errors++;
        $display("FAIL stall_out[%0d]: got v=%b tag=%0d src=%b last=%h expected v=%b tag=%0d", k, out_valid, out_tag, out_src, out_last_addr, vld_tab[k], tag_tab[k]);
      end
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_last_addr !== 32'h1033) begin errors++; $display("FAIL stall_tail: got v=%b tag=%0d last=%h expected 1/3/00001033", out_valid, out_tag, out_last_addr); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_ovf;
    do_single(1, 32'hFFFF_FFF0, 32'h10, 4'b0001, 3'd0, 4'd5);
    checks++; if (out_last_addr !== 32'h0) begin errors++; $display("FAIL ovf_last: got %h expected 00000000", out_last_addr); end
    checks++; if (out_fault !== 1'b1 || out_fault_ovf !== 1'b1 || out_fault_size !== 1'b0) begin errors++; $display("FAIL ovf_flags: got f=%b ovf=%b size=%b expected 1/1/0", out_fault, out_fault_ovf, out_fault_size); end
    checks++; if (out_src !== 1'b1 || out_tag !== 4'd5) begin errors++; $display("FAIL ovf_src_tag: got %b/%0d expected 1/5", out_src, out_tag); end
  endtask

  task automatic test_size;
    do_single(0, 32'h100, 32'h0, 4'b0110, 3'd0, 4'd6);
    checks++; if (out_last_addr !== 32'h100 || out_fault !== 1'b1 || out_fault_size !== 1'b1 || out_fault_ovf !== 1'b0) begin errors++; $display("FAIL size_0110: got last=%h f=%b size=%b ovf=%b expected 00000100/1/1/0", out_last_addr, out_fault, out_fault_size, out_fault_ovf); end
    do_single(1, 32'h100, 32'h0, 4'b0000, 3'd0, 4'd7);
    checks++; if (out_last_addr !== 32'h100 || out_fault !== 1'b1 || out_fault_size !== 1'b1 || out_fault_ovf !== 1'b0) begin errors++; $display("FAIL size_0000: got last=%h f=%b size=%b ovf=%b expected 00000100/1/1/0", out_last_addr, out_fault, out_fault_size, out_fault_ovf); end
  endtask

  task automatic test_cfg_same_edge;
    apply_reset;
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_seg = 3'd2; cfg_limit = 32'h10;
    b[0] = 32'h1D; d[0] = 32'h0; s[0] = 4'b0100; g[0] = 3'd2; t[0] = 4'd8;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cfg_accept: got %b expected 01", req_ready); end
    @(posedge clk); #1;
    cfg_we = 1'b0; req_valid = 2'b00;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_last_addr !== 32'h20 || out_fault !== 1'b0) begin errors++; $display("FAIL cfg_old_limit: got v=%b last=%h f=%b expected 1/00000020/0", out_valid, out_last_addr, out_fault); end
    do_single(0, 32'h1D, 32'h0, 4'b0100, 3'd2, 4'd9);
    checks++; if (out_last_addr !== 32'h20 || out_fault !== 1'b1) begin errors++; $display("FAIL cfg_new_limit: got last=%h f=%b expected 00000020/1", out_last_addr, out_fault); end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    cfg_we = 1'b1; cfg_seg = 3'd0; cfg_limit = 32'h5;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin b[i] = 32'h100; d[i] = 32'h0; s[i] = 4'b0001; g[i] = 3'd0; t[i] = 4'(10 + i); end
    req_valid = 2'b11;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL mid_full: got v=%b f=%b rdy=%b expected 1/1/00", out_valid, out_fault, req_ready); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_fault !== 1'b0 || out_last_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_outputs: got v=%b f=%b last=%h expected 0/0/0", out_valid, out_fault, out_last_addr); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_rst_ready: got %b expected 00", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_rr_ptr: got %b expected 01", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_tag !== 4'd10 || out_fault !== 1'b0 || out_last_addr !== 32'h100) begin errors++; $display("FAIL mid_table_reset: got v=%b src=%b tag=%0d f=%b last=%h expected 1/0/10/0/00000100", out_valid, out_src, out_tag, out_fault, out_last_addr); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_drain: got %b expected 0", out_valid); end
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_seg = '0; cfg_limit = '0;
    req_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin b[i] = '0; d[i] = '0; s[i] = 4'b0001; g[i] = '0; t[i] = '0; end
    #1;
    test_reset;
    test_limit;
    test_round_robin;
    test_stall;
    test_ovf;
    test_size;
    test_cfg_same_edge;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
